// File: rtl/gpu_fill_engine.sv
// Fill engine: turns one latched constant-colour fill command into a series of
// SDRAM write bursts, tracking protocol violations from the write-port controller.
module gpu_fill_engine #(
  parameter int H_RES     = 1024,
  parameter int ADDR_W    = 24,
  parameter int BASE_ADDR = 0,
  parameter int MAX_BURST = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0]       x_pos,
  input  logic [15:0]       y_pos,
  input  logic [23:0]       pixel,
  input  logic [23:0]       len,
  input  logic              enable,
  input  logic [8:0]        sys_wr_len,
  input  logic              init_done,
  output logic              busy,
  output logic              sys_vaild,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_len,
  input  logic              wr_ack,
  input  logic              wr_data_rd,
  output logic [15:0]       wr_data,
  input  logic              wr_done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]        r_state;
  logic              r_busy;
  logic              r_wr_req;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [8:0]        r_wr_len;
  logic [15:0]       r_wr_data;
  logic              r_err;
  logic [23:0]       r_remaining;
  logic [8:0]        r_beat;
  logic [8:0]        r_swl;

  logic              w_accept;
  logic              w_proto_err;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_start_addr;
  logic [23:0]       w_rem_after;

  // Burst size: remaining words, limited by the requested length (0 treated as 1) and MAX_BURST.
  function automatic logic [8:0] burst_len(input logic [23:0] rem, input logic [8:0] req);
    logic [23:0] cap;
    cap = (req == 9'd0) ? 24'd1 : {15'd0, req};
    cap = (cap > 24'(MAX_BURST)) ? 24'(MAX_BURST) : cap;
    cap = (rem < cap) ? rem : cap;
    return cap[8:0];
  endfunction

  // Command accept, start address, post-burst remaining count and protocol checks.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && enable && init_done;
    w_start_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(y_pos) * ADDR_W'(H_RES) + ADDR_W'(x_pos);
    w_rem_after  = r_remaining - {15'd0, r_wr_len};
    w_last_beat  = (r_beat + 9'd1) == r_wr_len;
    w_proto_err  = (wr_data_rd && (r_state != S_DATA)) ||
                   (wr_done && (r_state != S_WAIT)) ||
                   (wr_ack && !r_wr_req);
  end

  // Main sequencer: accept, request, count beats, await commit, hold in FINISH until enable drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_wr_req    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_len    <= 9'd0;
      r_wr_data   <= 16'd0;
      r_err       <= 1'b0;
      r_remaining <= 24'd0;
      r_beat      <= 9'd0;
      r_swl       <= 9'd0;
    end else begin
      r_err <= w_accept ? 1'b0 : (r_err | w_proto_err);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr_data   <= {pixel[23:19], pixel[15:10], pixel[7:3]};
            r_swl       <= sys_wr_len;
            r_wr_addr   <= w_start_addr;
            r_remaining <= len;
            r_busy      <= 1'b1;
            r_beat      <= 9'd0;
            if (len == 24'd0) begin
              r_state <= S_FINISH;
            end else begin
              r_state  <= S_REQ;
              r_wr_req <= 1'b1;
              r_wr_len <= burst_len(len, sys_wr_len);
            end
          end
        end
        S_REQ: begin
          if (wr_ack) begin
            r_wr_req <= 1'b0;
            r_beat   <= 9'd0;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (wr_data_rd) begin
            if (w_last_beat) begin
              r_beat  <= 9'd0;
              r_state <= S_WAIT;
            end else begin
              r_beat <= r_beat + 9'd1;
            end
          end
        end
        S_WAIT: begin
          if (wr_done) begin
            r_wr_addr   <= r_wr_addr + ADDR_W'(r_wr_len);
            r_remaining <= w_rem_after;
            if (w_rem_after == 24'd0) begin
              r_busy  <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_wr_req <= 1'b1;
              r_wr_len <= burst_len(w_rem_after, r_swl);
              r_state  <= S_REQ;
            end
          end
        end
        S_FINISH: begin
          // busy drops here for zero-length commands; enable must fall before re-arming.
          r_busy <= 1'b0;
          if (!enable) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_wr_req <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign sys_vaild = init_done && (r_state == S_IDLE);
  assign wr_req    = r_wr_req;
  assign wr_addr   = r_wr_addr;
  assign wr_len    = r_wr_len;
  assign wr_data   = r_wr_data;
  assign err       = r_err;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Scoreboard bench for gpu_fill_engine: expected bursts are queued per command and
// a monitor compares every new write request; a responder models the SDRAM port.
module tb_gpu_fill_engine;

  logic        clk;
  logic        rstn;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic [23:0] pixel;
  logic [23:0] len;
  logic        enable;
  logic [8:0]  sys_wr_len;
  logic        init_done;
  logic        busy;
  logic        sys_vaild;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [8:0]  wr_len;
  logic        wr_ack;
  logic        wr_data_rd;
  logic [15:0] wr_data;
  logic        wr_done;
  logic        err;

  gpu_fill_engine dut (
    .clk(clk), .rstn(rstn), .x_pos(x_pos), .y_pos(y_pos), .pixel(pixel), .len(len),
    .enable(enable), .sys_wr_len(sys_wr_len), .init_done(init_done), .busy(busy),
    .sys_vaild(sys_vaild), .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_ack(wr_ack), .wr_data_rd(wr_data_rd), .wr_data(wr_data), .wr_done(wr_done),
    .err(err)
  );

  typedef struct packed {
    logic [23:0] a;
    logic [8:0]  l;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   ack_delay = 0;
  int   gap = 0;
  int   extra_beat = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [23:0] a, input logic [8:0] l, input logic [15:0] d);
    exp_t e;
    e.a = a; e.l = l; e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each new request against the scoreboard, then check it is held stable.
  initial begin
    logic        prev_req;
    logic [23:0] held_addr;
    logic [8:0]  held_len;
    exp_t        e;
    prev_req = 1'b0; held_addr = 24'd0; held_len = 9'd0;
    forever begin
      @(negedge clk);
      if (wr_req === 1'b1 && prev_req !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: got addr %0d len %0d, no burst expected", wr_addr, wr_len);
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", 32'(wr_addr), 32'(e.a));
          chk("req_len", 32'(wr_len), 32'(e.l));
          chk("req_data", 32'(wr_data), 32'(e.d));
        end
        held_addr = wr_addr;
        held_len  = wr_len;
      end else if (wr_req === 1'b1) begin
        chk("req_stable_addr", 32'(wr_addr), 32'(held_addr));
        chk("req_stable_len", 32'(wr_len), 32'(held_len));
      end
      prev_req = wr_req;
    end
  end

  // Responder: grant after ack_delay, supply wr_len beats with gaps, then commit.
  initial begin
    int n;
    wr_ack = 1'b0; wr_data_rd = 1'b0; wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req === 1'b1) begin
        repeat (ack_delay) @(negedge clk);
        n = int'(wr_len);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        for (int b = 0; b < n; b++) begin
          repeat (gap) @(negedge clk);
          wr_data_rd = 1'b1;
          @(negedge clk);
          wr_data_rd = 1'b0;
        end
        if (extra_beat != 0) begin
          wr_data_rd = 1'b1;
          @(negedge clk);
          wr_data_rd = 1'b0;
        end
        @(negedge clk);
        wr_done  = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        wr_done = 1'b0;
      end
    end
  end

  task automatic run_cmd(input logic [15:0] x, input logic [15:0] y, input logic [23:0] pix,
                         input logic [23:0] l, input logic [8:0] swl, input logic exp_err);
    int n;
    x_pos = x; y_pos = y; pixel = pix; len = l; sys_wr_len = swl;
    enable = 1'b1;
    @(negedge clk);
    chk("busy_on_accept", 32'(busy), 32'd1);
    // Scramble inputs: the latched copies must be used.
    x_pos = 16'hFFFF; y_pos = 16'h00FF; pixel = 24'h000000; len = 24'd5; sys_wr_len = 9'd1;
    if (l == 24'd0) begin
      @(negedge clk);
      chk("busy_len0_one_cycle", 32'(busy), 32'd0);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk("busy_fall_in_budget", 32'(n < 5000), 32'd1);
      chk("busy_fall_after_done", 32'(cyc - done_cyc), 32'd1);
    end
    chk("bursts_outstanding", 32'(exp_q.size()), 32'd0);
    chk("err_at_end", 32'(err), 32'(exp_err));
    repeat (3) @(negedge clk);
    chk("busy_stays_low", 32'(busy), 32'd0);
    chk("vaild_low_in_finish", 32'(sys_vaild), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    chk("vaild_after_enable_low", 32'(sys_vaild), 32'd1);
  endtask

  initial begin
    int n;
    rstn = 1'b0; init_done = 1'b0; enable = 1'b0;
    x_pos = 16'd0; y_pos = 16'd0; pixel = 24'd0; len = 24'd0; sys_wr_len = 9'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_len", 32'(wr_len), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("vaild_no_init", 32'(sys_vaild), 32'd0);

    // Gating: enable without init_done must not start a command.
    x_pos = 16'd1; y_pos = 16'd1; len = 24'd4; sys_wr_len = 9'd4; enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("gate_busy", 32'(busy), 32'd0);
    chk("gate_vaild", 32'(sys_vaild), 32'd0);
    enable = 1'b0; init_done = 1'b1;
    @(negedge clk);
    chk("vaild_with_init", 32'(sys_vaild), 32'd1);

    // Single burst.
    push_exp(24'd2058, 9'd8, 16'hFC08);
    run_cmd(16'd10, 16'd2, 24'hFF8040, 24'd8, 9'd16, 1'b0);

    // Multi-burst 256/256/88.
    push_exp(24'd5120, 9'd256, 16'h11AA);
    push_exp(24'd5376, 9'd256, 16'h11AA);
    push_exp(24'd5632, 9'd88, 16'h11AA);
    run_cmd(16'd0, 16'd5, 24'h123456, 24'd600, 9'd256, 1'b0);

    // Requested length above MAX_BURST is clamped.
    push_exp(24'd0, 9'd256, 16'h0000);
    push_exp(24'd256, 9'd44, 16'h0000);
    run_cmd(16'd0, 16'd0, 24'h000000, 24'd300, 9'd400, 1'b0);

    // Zero requested length behaves as bursts of one.
    push_exp(24'd1031, 9'd1, 16'hFFFF);
    push_exp(24'd1032, 9'd1, 16'hFFFF);
    push_exp(24'd1033, 9'd1, 16'hFFFF);
    run_cmd(16'd7, 16'd1, 24'hFFFFFF, 24'd3, 9'd0, 1'b0);

    // Zero-length command: one busy cycle, no request.
    run_cmd(16'd1, 16'd1, 24'h808080, 24'd0, 9'd8, 1'b0);

    // Stalled grant, gapped beats, then a stray beat after the last one.
    ack_delay = 20; gap = 3; extra_beat = 1;
    push_exp(24'd3172, 9'd5, 16'h07E0);
    run_cmd(16'd100, 16'd3, 24'h00FF00, 24'd5, 9'd8, 1'b1);

    // Next command clears err.
    ack_delay = 0; gap = 0; extra_beat = 0;
    push_exp(24'd0, 9'd2, 16'h001F);
    run_cmd(16'd0, 16'd0, 24'h0000FF, 24'd2, 9'd2, 1'b0);

    // Address wraps past the top of the word space.
    push_exp(24'hFFFFFC, 9'd4, 16'hF800);
    push_exp(24'h000000, 9'd4, 16'hF800);
    run_cmd(16'd1020, 16'd16383, 24'hFF0000, 24'd8, 9'd4, 1'b0);

    // Asynchronous reset in the middle of a data phase.
    gap = 1;
    push_exp(24'd0, 9'd256, 16'h0000);
    x_pos = 16'd0; y_pos = 16'd0; pixel = 24'h000000; len = 24'd600; sys_wr_len = 9'd256;
    enable = 1'b1;
    n = 0;
    while (wr_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    while (wr_req === 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("reach_data_in_budget", 32'(n < 200), 32'd1);
    repeat (4) @(negedge clk);
    chk("mid_data_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_wr_req", 32'(wr_req), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("vaild_after_reset", 32'(sys_vaild), 32'd1);
    chk("busy_after_reset", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_fill_engine.md
Name: gpu_fill_engine

Overview:
Consumer end of the GPU command-register interface (x_pos/y_pos/pixel/len/enable/sys_wr_len in, sys_vaild/busy out). It turns one latched fill command into a sequence of SDRAM write bursts of a constant colour. It sits between the GPU register block and the SDRAM write-port controller, replacing the fill logic inside the display subsystem.

Parameters:
H_RES, 1024, pixels per framebuffer line (address stride of y)
ADDR_W, 24, SDRAM word-address width
BASE_ADDR, 0, framebuffer base word address
MAX_BURST, 256, largest burst issued; sys_wr_len is clamped to this value

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
x_pos  in  16  start column
y_pos  in  16  start row
pixel  in  24  fill colour, RGB888 {R,G,B}
len  in  24  pixel count to write
enable  in  1  level command request from the register block
sys_wr_len  in  9  requested burst length
init_done  in  1  SDRAM initialisation complete (synchronous to clk)
busy  out  1  command in progress
sys_vaild  out  1  engine ready: init_done high and state IDLE
wr_req  out  1  burst request
wr_addr  out  ADDR_W  burst start word address
wr_len  out  9  burst length in words
wr_ack  in  1  one-cycle grant of wr_req
wr_data_rd  in  1  downstream consumes one word this cycle
wr_data  out  16  RGB565 fill word
wr_done  in  1  one-cycle pulse: burst committed to SDRAM
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rstn=0): state IDLE. busy, wr_req, err = 0. wr_addr, wr_len, wr_data = 0. All internal counters 0. Reset mid-burst abandons the burst; the downstream controller is reset by the same rstn.
- wr_data = {pixel[23:19], pixel[15:10], pixel[7:3]}, latched at command accept and held constant for the whole command.
- States: IDLE, REQ, DATA, WAIT_DONE, FINISH.
- IDLE: when enable=1 and init_done=1, latch all command inputs. Set start address = BASE_ADDR + y_pos*H_RES + x_pos, modulo 2^ADDR_W. Set remaining = len and busy=1 on the next edge; clear err. If len==0, go to FINISH; otherwise go to REQ. With init_done=0, enable is ignored.
- Burst size: eff = min(remaining, max(sys_wr_len_latched, 1), MAX_BURST). It is computed when entering REQ.
- REQ: wr_req=1, with wr_addr and wr_len=eff stable until wr_ack. When wr_ack is sampled high, wr_req drops on the next edge and the state moves to DATA.
- DATA: each wr_data_rd=1 cycle counts one beat. After beat eff, go to WAIT_DONE.
- WAIT_DONE: on wr_done, addr += eff (wraps modulo 2^ADDR_W) and remaining -= eff. If remaining==0, go to FINISH; otherwise go to REQ.
- Addressing: no clipping at line end. Fills run linearly into the following rows.
- FINISH: busy=0. Stay in FINISH until enable=0, then go to IDLE. This prevents re-triggering while the register block clears enable several cycles after seeing busy fall.
- busy stays high for at least 1 cycle per accepted command, including len==0.
- err is set when any of the following occurs:
  - wr_data_rd outside DATA
  - wr_done outside WAIT_DONE
  - wr_ack while wr_req=0
  The offending strobe is otherwise ignored. err is sticky until the next accepted command or reset.
- Input changes while busy=1 have no effect; the latched copies are used.
- Simultaneous wr_done and the last beat cannot occur (they arrive in different states). A wr_done pulse arriving in DATA sets err.

Test Plan:
- Reset: rstn=0 mid-DATA → busy=0, wr_req=0, err=0 immediately. After release with init_done=1 → sys_vaild=1.
- Single burst: x=10, y=2, H_RES=1024, len=8, sys_wr_len=16, pixel=0xFF8040 → one request with wr_addr=2058, wr_len=8, wr_data=0xFC08. Busy falls 1 cycle after wr_done and stays low; IDLE is reached only after enable drops.
- Multi-burst: len=600, sys_wr_len=256 → bursts of 256, 256, 88 at addresses A, A+256, A+512. busy stays high throughout.
- Clamp/zero: sys_wr_len=400 → bursts of 256. sys_wr_len=0, len=3 → three bursts of 1. len=0 → busy high exactly 1 cycle and no wr_req.
- Handshake stall: wr_ack delayed 20 cycles and wr_data_rd gapped → wr_addr/wr_len held stable and exact beat count honoured. An extra wr_data_rd after the last beat → err=1, which clears on the next command.
- Gating/wrap: init_done=0 with enable=1 → no accept and sys_vaild=0. Start address 2^24-4 with len=8 → second half of the writes wraps to address 0.
